// File: rtl/uart_pkg.sv
// Shared types and default parameters for the UART blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; RST_VAL sets the
// level both flops take in reset, so an idle line never reads as active.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers 8N1 frames from an oversampled serial line and
// presents each byte with a one-cycle done strobe (or a frame-error strobe).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tick,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_done,
  output logic                 o_rx_frame_err,
  output logic                 o_rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [TW-1:0] LP_MID_START = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LP_MID_BIT   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LP_LAST_BIT  = BW'(DATA_BITS - 1);

  rx_state_t              r_state;
  rx_state_t              w_state_nxt;
  logic [TW-1:0]          r_tick_cnt;
  logic [BW-1:0]          r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   r_done;
  logic                   r_ferr;
  logic                   w_rx;
  logic                   w_mid_start;
  logic                   w_mid_bit;
  logic                   w_last_bit;
  logic                   w_busy;

  uart_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_rxd),
    .o_q    (w_rx)
  );

  assign w_mid_start = i_tick && (r_tick_cnt == LP_MID_START);
  assign w_mid_bit   = i_tick && (r_tick_cnt == LP_MID_BIT);
  assign w_last_bit  = (r_bit_cnt == LP_LAST_BIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_rx) w_state_nxt = START;
      START:   if (w_mid_start) w_state_nxt = w_rx ? IDLE : DATA;
      DATA:    if (w_mid_bit && w_last_bit) w_state_nxt = STOP;
      STOP:    if (w_mid_bit) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != IDLE);
  end

  // The tick counter is cleared at every compare point so it never relies on wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rx_data  <= '0;
      r_done     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx) r_tick_cnt <= '0;
        end
        START: begin
          if (w_mid_start) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
          end else if (i_tick) begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
          end
        end
        DATA: begin
          if (w_mid_bit) begin
            r_shift    <= {w_rx, r_shift[DATA_BITS-1:1]};
            r_tick_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + BW'(1);
          end else if (i_tick) begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
          end
        end
        STOP: begin
          if (w_mid_bit) begin
            r_tick_cnt <= '0;
            if (w_rx) begin
              r_rx_data <= r_shift;
              r_done    <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
          end else if (i_tick) begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rx_data      = r_rx_data;
  assign o_rx_done      = r_done;
  assign o_rx_frame_err = r_ferr;
  assign o_rx_busy      = w_busy;

endmodule
